// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and types for the mouse bring-up sequencer.
package ps2_pkg;

    // Host-to-device commands and arguments
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] RATE_100     = 8'h64;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // Device-to-host responses
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_MOUSE_ID = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_RELEASE,
        ST_DONE,
        ST_FAIL
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_TX_TIMEOUT   = 3'd1,
        ERR_RESP_TIMEOUT = 3'd2,
        ERR_BAD_RESP     = 3'd3,
        ERR_BAT_FAIL     = 3'd4
    } err_code_e;

    typedef struct packed {
        logic [7:0] cmd;
        logic       expect_bat;
    } script_entry_t;

endpackage

// File: rtl/ps2_resp_timer.sv
// Response-window counter: cleared on state entry, counts while enabled,
// flags when the count reaches the supplied limit.
module ps2_resp_timer #(
    parameter int TIMER_BITS = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [TIMER_BITS-1:0] limit,
    output logic                  expired
);

    logic [TIMER_BITS-1:0] count;

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TIMER_BITS'(1);
        end
    end

    assign expired = enable && (count == limit);

endmodule

// File: rtl/ps2_mouse_init_sequencer.sv
// Drives the PS/2 command transmitter through the mouse bring-up script
// (reset, set sample rate 100, enable streaming) with per-step retries.
module ps2_mouse_init_sequencer
    import ps2_pkg::*;
#(
    parameter int ACK_TIMEOUT_CYCLES = 1000000,
    parameter int BAT_TIMEOUT_CYCLES = 25000000,
    parameter int MAX_RETRIES        = 3,
    parameter int TIMER_BITS         = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       cmd_sent,
    input  logic       cmd_timeout,
    output logic [7:0] cmd_data,
    output logic       cmd_send,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] error_code,
    output logic [1:0] step
);

    localparam int RETRY_BITS = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_BITS-1:0] RETRY_LIMIT = RETRY_BITS'(MAX_RETRIES);

    // The timer counts cycles already spent in the wait state, so the
    // window closes on the cycle whose count is (timeout - 1).
    localparam logic [TIMER_BITS-1:0] ACK_LAST = TIMER_BITS'(ACK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_BITS-1:0] BAT_LAST = TIMER_BITS'(BAT_TIMEOUT_CYCLES - 1);

    state_e                state, state_next;
    logic [1:0]            step_q, step_next;
    logic [RETRY_BITS-1:0] retries_q, retries_next;
    err_code_e             code_q, code_next;
    err_code_e             fail_cause;
    logic                  retry_req;
    logic                  advance;
    script_entry_t         entry;

    logic                  timer_clear;
    logic                  timer_enable;
    logic                  timer_expired;
    logic [TIMER_BITS-1:0] timer_limit;

    function automatic script_entry_t script_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    script_rom = '{cmd: CMD_RESET,    expect_bat: 1'b1};
            2'd1:    script_rom = '{cmd: CMD_SET_RATE, expect_bat: 1'b0};
            2'd2:    script_rom = '{cmd: RATE_100,     expect_bat: 1'b0};
            default: script_rom = '{cmd: CMD_ENABLE,   expect_bat: 1'b0};
        endcase
    endfunction

    assign entry = script_rom(step_q);

    assign timer_enable = (state == ST_WAIT_ACK) || (state == ST_WAIT_BAT) || (state == ST_WAIT_ID);
    assign timer_clear  = (state_next != state);
    assign timer_limit  = (state == ST_WAIT_BAT) ? BAT_LAST : ACK_LAST;

    ps2_resp_timer #(
        .TIMER_BITS (TIMER_BITS)
    ) u_resp_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            step_q    <= '0;
            retries_q <= '0;
            code_q    <= ERR_NONE;
        end else begin
            state     <= state_next;
            step_q    <= step_next;
            retries_q <= retries_next;
            code_q    <= code_next;
        end
    end

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        state_next   = state;
        step_next    = step_q;
        retries_next = retries_q;
        code_next    = code_q;
        fail_cause   = ERR_NONE;
        retry_req    = 1'b0;
        advance      = 1'b0;

        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_next   = ST_SEND;
                    step_next    = '0;
                    retries_next = '0;
                    code_next    = ERR_NONE;
                end
            end
            ST_SEND: begin
                if (cmd_sent) begin
                    state_next = ST_WAIT_ACK;
                end else if (cmd_timeout) begin
                    retry_req  = 1'b1;
                    fail_cause = ERR_TX_TIMEOUT;
                end
            end
            ST_WAIT_ACK: begin
                if (rx_valid) begin
                    if (rx_data != RSP_ACK) begin
                        retry_req  = 1'b1;
                        fail_cause = ERR_BAD_RESP;
                    end else if (entry.expect_bat) begin
                        state_next = ST_WAIT_BAT;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (timer_expired) begin
                    retry_req  = 1'b1;
                    fail_cause = ERR_RESP_TIMEOUT;
                end
            end
            ST_WAIT_BAT: begin
                if (rx_valid) begin
                    if (rx_data == RSP_BAT_OK) begin
                        state_next = ST_WAIT_ID;
                    end else if (rx_data == RSP_BAT_FAIL) begin
                        // Self-test failure is fatal; retrying cannot help.
                        state_next = ST_FAIL;
                        code_next  = ERR_BAT_FAIL;
                    end else begin
                        retry_req  = 1'b1;
                        fail_cause = ERR_BAD_RESP;
                    end
                end else if (timer_expired) begin
                    retry_req  = 1'b1;
                    fail_cause = ERR_RESP_TIMEOUT;
                end
            end
            ST_WAIT_ID: begin
                if (rx_valid) begin
                    if (rx_data == RSP_MOUSE_ID) begin
                        advance = 1'b1;
                    end else begin
                        retry_req  = 1'b1;
                        fail_cause = ERR_BAD_RESP;
                    end
                end else if (timer_expired) begin
                    retry_req  = 1'b1;
                    fail_cause = ERR_RESP_TIMEOUT;
                end
            end
            ST_RELEASE: begin
                state_next = ST_SEND;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (step_q == 2'd3) begin
                state_next = ST_DONE;
            end else begin
                step_next    = step_q + 2'd1;
                retries_next = '0;
                state_next   = ST_RELEASE;
            end
        end

        if (retry_req) begin
            code_next = fail_cause;
            if (retries_q < RETRY_LIMIT) begin
                retries_next = retries_q + RETRY_BITS'(1);
                state_next   = ST_RELEASE;
            end else begin
                state_next = ST_FAIL;
            end
        end
    end

    always_comb begin
        cmd_send   = (state == ST_SEND);
        cmd_data   = cmd_send ? entry.cmd : 8'h00;
        busy       = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));
        done       = (state == ST_DONE);
        error      = (state == ST_FAIL);
        error_code = code_q;
        step       = step_q;
    end

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Directed bench for the PS/2 mouse init sequencer with transmitter and
// device models, a script-level expectation model and a per-cycle checker.
module tb_ps2_mouse_init_sequencer;
    import ps2_pkg::*;

    localparam int ACK_T  = 20;
    localparam int BAT_T  = 200;
    localparam int MAX_R  = 3;
    localparam int TX_LAT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       cmd_sent = 1'b0;
    logic       cmd_timeout = 1'b0;
    logic [7:0] cmd_data;
    logic       cmd_send;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] error_code;
    logic [1:0] step;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         due;
        logic [7:0] data;
    } resp_t;

    resp_t      resp_q[$];
    logic [7:0] exp_q[$];
    int         rise_cyc[$];
    logic [7:0] rise_byte[$];
    int         fall_cyc[$];
    int         busy_fall_cyc = 0;
    int         err_cyc = 0;
    int         last_rx_cyc = 0;
    int         fe_cyc = 0;

    bit         tx_to_en = 1'b0;
    logic [7:0] tx_to_byte = 8'h00;
    int         nak_f3 = 0;
    bit         silent_f4 = 1'b0;
    bit         bat_fail = 1'b0;
    bit         exp_done = 1'b0;
    logic [2:0] exp_code = 3'd0;

    ps2_mouse_init_sequencer #(
        .ACK_TIMEOUT_CYCLES (ACK_T),
        .BAT_TIMEOUT_CYCLES (BAT_T),
        .MAX_RETRIES        (MAX_R),
        .TIMER_BITS         (25)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd_sent    (cmd_sent),
        .cmd_timeout (cmd_timeout),
        .cmd_data    (cmd_data),
        .cmd_send    (cmd_send),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .error_code  (error_code),
        .step        (step)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Device replies to a successfully transmitted byte, timed from cycle t.
    task automatic schedule(input logic [7:0] b, input int t);
        if (b == CMD_RESET) begin
            resp_q.push_back('{due: t + 4, data: RSP_ACK});
            if (bat_fail) begin
                resp_q.push_back('{due: t + 10, data: RSP_BAT_FAIL});
            end else begin
                resp_q.push_back('{due: t + 10, data: RSP_BAT_OK});
                resp_q.push_back('{due: t + 14, data: RSP_MOUSE_ID});
            end
        end else if (b == CMD_SET_RATE && nak_f3 > 0) begin
            nak_f3--;
            resp_q.push_back('{due: t + 4, data: RSP_RESEND});
        end else if (!(b == CMD_ENABLE && silent_f4)) begin
            resp_q.push_back('{due: t + 4, data: RSP_ACK});
        end
    endtask

    // Transmitter: reports sent/timeout TX_LAT cycles after send rises, holds it while send is high.
    initial begin : tx_model
        int lat;
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!cmd_send) begin
                cmd_sent    = 1'b0;
                cmd_timeout = 1'b0;
                lat         = 0;
            end else if (!cmd_sent && !cmd_timeout) begin
                lat++;
                if (lat == TX_LAT) begin
                    if (tx_to_en && cmd_data == tx_to_byte) begin
                        cmd_timeout = 1'b1;
                    end else begin
                        cmd_sent = 1'b1;
                        schedule(cmd_data, cyc);
                    end
                end
            end
        end
    end

    initial begin : device_model
        forever begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            if (resp_q.size() != 0 && cyc >= resp_q[0].due) begin
                rx_valid    = 1'b1;
                rx_data     = resp_q[0].data;
                last_rx_cyc = cyc;
                if (rx_data == RSP_RESEND) fe_cyc = cyc;
                resp_q.delete(0);
            end
        end
    end

    // Script-level model: expected transmit attempts and final outcome for the current device setup.
    task automatic build_expected();
        logic [7:0] script [4];
        int         naks;
        script[0] = CMD_RESET;
        script[1] = CMD_SET_RATE;
        script[2] = RATE_100;
        script[3] = CMD_ENABLE;
        naks      = nak_f3;
        exp_q.delete();
        exp_done  = 1'b1;
        exp_code  = 3'd0;
        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a <= MAX_R; a++) begin
                logic [2:0] cause;
                exp_q.push_back(script[s]);
                cause = 3'd0;
                if (tx_to_en && script[s] == tx_to_byte) begin
                    cause = 3'd1;
                end else if (s == 0 && bat_fail) begin
                    exp_done = 1'b0;
                    exp_code = 3'd4;
                    return;
                end else if (s == 1 && naks > 0) begin
                    naks--;
                    cause = 3'd3;
                end else if (s == 3 && silent_f4) begin
                    cause = 3'd2;
                end
                if (cause == 3'd0) break;
                exp_code = cause;
                if (a == MAX_R) begin
                    exp_done = 1'b0;
                    return;
                end
            end
        end
    endtask

    // Per-cycle checker on the falling edge.
    initial begin : compare
        logic       prev_send;
        logic       prev_busy;
        logic       prev_err;
        logic [7:0] held;
        prev_send = 1'b0;
        prev_busy = 1'b0;
        prev_err  = 1'b0;
        held      = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_send = 1'b0;
                prev_busy = 1'b0;
                prev_err  = 1'b0;
            end else begin
                if (cmd_send && !prev_send) begin
                    rise_cyc.push_back(cyc);
                    rise_byte.push_back(cmd_data);
                    held = cmd_data;
                    check("tx_attempt_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("tx_byte", cmd_data, exp_q.pop_front());
                end
                if (cmd_send && prev_send) check("cmd_data_stable", cmd_data, held);
                if (!cmd_send && prev_send) fall_cyc.push_back(cyc);
                if (cmd_send) check("busy_during_send", busy, 1);
                check("done_error_exclusive", done & error, 0);
                check("busy_vs_flags", busy & (done | error), 0);
                if (!busy && prev_busy) busy_fall_cyc = cyc;
                if (error && !prev_err) err_cyc = cyc;
                prev_send = cmd_send;
                prev_busy = busy;
                prev_err  = error;
            end
        end
    end

    task automatic setup(input bit to_en, input logic [7:0] to_byte, input int naks,
                         input bit silent, input bit batf);
        tx_to_en   = to_en;
        tx_to_byte = to_byte;
        nak_f3     = naks;
        silent_f4  = silent;
        bat_fail   = batf;
        resp_q.delete();
        rise_cyc.delete();
        rise_byte.delete();
        fall_cyc.delete();
        build_expected();
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_cmd_send"}, cmd_send, 0);
        check({name, "_cmd_data"}, cmd_data, 8'h00);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_error"}, error, 0);
        check({name, "_error_code"}, error_code, 0);
        check({name, "_step"}, step, 0);
    endtask

    task automatic wait_finish(input string name);
        int n;
        n = 0;
        while (!(done || error) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check({name, "_finished"}, done | error, 1);
        check({name, "_done"}, done, exp_done);
        check({name, "_error"}, error, !exp_done);
        check({name, "_error_code"}, error_code, exp_code);
        check({name, "_busy"}, busy, 0);
        check({name, "_all_sent"}, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n_f3;
        int f3_rise;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("reset");

        // Happy path
        setup(1'b0, 8'h00, 0, 1'b0, 1'b0);
        pulse_start();
        check("start_busy", busy, 1);
        check("start_cmd_send", cmd_send, 1);
        check("start_cmd_data", cmd_data, 8'hFF);
        check("start_step", step, 0);
        wait_finish("happy");
        check("happy_attempts", rise_byte.size(), 4);
        if (rise_byte.size() == 4) begin
            check("happy_byte0", rise_byte[0], 8'hFF);
            check("happy_byte1", rise_byte[1], 8'hF3);
            check("happy_byte2", rise_byte[2], 8'h64);
            check("happy_byte3", rise_byte[3], 8'hF4);
        end
        check("happy_code_literal", error_code, 0);
        check("happy_step", step, 3);
        check("happy_busy_fall_latency", busy_fall_cyc - last_rx_cyc, 1);

        // One resend of 0xF3
        setup(1'b0, 8'h00, 1, 1'b0, 1'b0);
        pulse_start();
        wait_finish("resend");
        check("resend_attempts", rise_byte.size(), 5);
        n_f3    = 0;
        f3_rise = 0;
        for (int i = 0; i < rise_byte.size(); i++) begin
            if (rise_byte[i] == 8'hF3) begin
                n_f3++;
                if (n_f3 == 2) f3_rise = rise_cyc[i];
            end
        end
        check("resend_f3_count", n_f3, 2);
        check("resend_release_gap", f3_rise - fe_cyc, 2);
        check("resend_code_literal", error_code, 3);

        // BAT failure
        setup(1'b0, 8'h00, 0, 1'b0, 1'b1);
        pulse_start();
        wait_finish("bat");
        check("bat_code_literal", error_code, 4);
        repeat (30) @(posedge clk);
        #1;
        check("bat_attempts", rise_byte.size(), 1);
        check("bat_cmd_send_low", cmd_send, 0);

        // Silent device on 0xF4
        setup(1'b0, 8'h00, 0, 1'b1, 1'b0);
        pulse_start();
        wait_finish("silent");
        check("silent_code_literal", error_code, 2);
        check("silent_attempts", rise_byte.size(), 7);
        if (rise_byte.size() == 7 && fall_cyc.size() == 7) begin
            for (int i = 3; i < 6; i++) begin
                check("silent_f4_byte", rise_byte[i + 1], 8'hF4);
                check("silent_window_gap", rise_cyc[i + 1] - fall_cyc[i], ACK_T + 1);
            end
            check("silent_final_window", err_cyc - fall_cyc[6], ACK_T);
        end

        // Transmit timeout on every 0xFF attempt, then restart with a good device
        setup(1'b1, 8'hFF, 0, 1'b0, 1'b0);
        pulse_start();
        wait_finish("txto");
        check("txto_code_literal", error_code, 1);
        check("txto_attempts", rise_byte.size(), 4);
        setup(1'b0, 8'h00, 0, 1'b0, 1'b0);
        pulse_start();
        check("restart_error_clear", error, 0);
        check("restart_code_clear", error_code, 0);
        check("restart_busy", busy, 1);
        wait_finish("restart");

        // Reset while sending, then a stray byte in IDLE
        setup(1'b0, 8'h00, 0, 1'b0, 1'b0);
        pulse_start();
        @(posedge clk);
        #1;
        check("midsend_cmd_send", cmd_send, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("midreset");
        reset = 1'b0;
        exp_q.delete();
        resp_q.push_back('{due: cyc + 1, data: RSP_ACK});
        repeat (5) @(posedge clk);
        #1;
        check("stray_delivered", resp_q.size(), 0);
        check_reset_values("stray");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
